demux16_stream: RTL
===================

# demux16_stream

Registered 1-to-2 demultiplexer for 16-bit data in the CPU datapath: it steers each accepted input word to channel A or channel B by a per-transfer select bit. Each channel holds the word in its own output register behind a valid/ready handshake. It is the fan-out counterpart of the 16-bit 2:1 mux, used where one producer (ALU result, load data) feeds two independently stalling consumers (register file write port, memory store path).

## Interface
Parameters:
- WIDTH, 16, data width in bits; ports below are WIDTH wide where marked.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  WIDTH  word to route.
- in_sel  input  1  0 = channel A, 1 = channel B; qualified by in_valid.
- in_valid  input  1  producer offers word.
- in_ready  output  1  block accepts word this cycle.
- a_data  output  WIDTH  channel A word.
- a_valid  output  1  channel A holds a word.
- a_ready  input  1  channel A consumer takes word.
- b_data, b_valid, b_ready  same as A, for channel B.
- a_count, b_count  output  16  per-channel transfer counts; present only with DEMUX16_COUNT_EN.

## Operation
- Accept: an input word is accepted when in_valid && in_ready.
- in_ready is combinational, decoded as sel ? b_free : a_free. Here x_free = !x_valid || x_ready.
- in_ready depends on in_sel and the channel state, never on in_valid.
- An accepted word is loaded into the selected channel's register, and that channel's valid is set on the next edge.
- The unselected channel is untouched: its data and valid hold, and it may drain independently.
- Drain: x_valid && x_ready clears x_valid on the next edge, unless a new word loads the same channel in that cycle.
- Simultaneous drain and load on one channel: the new word replaces the old one and x_valid stays 1. This gives one word per cycle sustained throughput per channel.
- A stalled channel (valid=1, ready=0) blocks only inputs addressed to it. An input for the other channel is still accepted.
- No reordering occurs within a channel. There is no ordering guarantee across channels.
- x_data is held stable while x_valid && !x_ready.
- Per-channel states: EMPTY (valid=0) and FULL (valid=1).
  - EMPTY→FULL on load.
  - FULL→EMPTY on drain without load.
  - FULL→FULL on load with drain, or on a stall.
- Producer rule: in_data and in_sel must be held while in_valid && !in_ready. Checked by assertion in the bench, not by RTL.

## Timing
- Latency: 1 cycle from input accept to x_valid=1.
- Reset values: a_valid=b_valid=0; a_data=b_data=0; a_count=b_count=0. in_ready after reset is 1 for either sel.
- Reset asserted mid-transfer: both registers are flushed asynchronously, and any word in flight or stalled is lost. The first accept is possible on the first edge after rst deasserts.
- Combinational paths: in_sel/a_ready/b_ready → in_ready. There is no path from in_valid to any output.

## Configuration
- DEMUX16_COUNT_EN defined:
  - a_count and b_count increment by 1 on each load into their channel. Loads are counted, not drains.
  - Counters are 16 bits and wrap 0xFFFF→0x0000 silently.
  - Reset clears both counters.
- DEMUX16_COUNT_EN undefined: the count ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package cpu16_pkg:
  - WORD_W = 16.
  - Channel select constants CH_A = 1'b0 and CH_B = 1'b1.
- Sub-module demux_out_stage, instantiated twice:
  - One output register plus valid flag with load/drain logic.
  - With DEMUX16_COUNT_EN, it also holds the channel's counter.
- Top level holds only the select decode and the in_ready mux.

## Test plan
- Reset then route: accept 0x1234 with sel=0, then 0xABCD with sel=1 on the next cycle, both consumers ready → a_data=0x1234 is valid 1 cycle after its accept and b_data=0xABCD 1 cycle after its own. Neither channel shows a spurious valid.
- Stall isolation: a_ready=0 and A full; offer sel=0 → in_ready=0 and a_data is held. Offer sel=1 word 0x5555 → accepted, b_data=0x5555 next cycle.
- Back-to-back throughput: 8 words 0x0001..0x0008, all sel=1, b_ready=1 → one accept per cycle, b_data sequence identical and in order, no bubbles.
- Load with drain: B full with 0x00AA and b_ready=1, accept 0x00BB with sel=1 in the same cycle → b_valid stays 1 and b_data=0x00BB next cycle.
- Reset mid-operation: A full and stalled with 0x7777; pulse rst between edges → a_valid=0 immediately and a_data=0. The next accept with sel=0 works normally.
- Counter wrap (DEMUX16_COUNT_EN): preload by 65535 loads to A → a_count=0xFFFF. One more load → a_count=0x0000, while b_count is unchanged.

Source files
------------

// File: rtl/cpu16_pkg.sv
// Shared CPU datapath definitions: word width, channel select codes and counter width.
// Used by demux16_stream and its demux_out_stage sub-module.
package cpu16_pkg;

  localparam int WORD_W  = 16;
  localparam int COUNT_W = 16;
  localparam int N_CH    = 2;

  localparam logic CH_A = 1'b0;
  localparam logic CH_B = 1'b1;

  // Per-channel "free" term: the register can take a word this cycle.
  function automatic logic chan_free(input logic valid, input logic ready);
    return !valid || ready;
  endfunction

endpackage

// File: rtl/demux_out_stage.sv
// One demux output channel: data register plus valid flag with load/drain handling.
// With DEMUX16_COUNT_EN defined it also keeps the channel's 16-bit load counter.
module demux_out_stage
  import cpu16_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_free
`ifdef DEMUX16_COUNT_EN
  ,
  output logic [COUNT_W-1:0] o_count
`endif
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]       r_state;
  logic [0:0]       w_state_next;
  logic [WIDTH-1:0] r_data;

  // A load wins over a drain, so a simultaneous drain+load stays FULL.
  always_comb begin
    w_state_next = r_state;
    if (i_load) begin
      w_state_next = ST_FULL;
    end else if (r_state == ST_FULL && i_ready) begin
      w_state_next = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_EMPTY;
      r_data  <= '0;
    end else begin
      r_state <= w_state_next;
      if (i_load) begin
        r_data <= i_data;
      end
    end
  end

  assign o_data  = r_data;
  assign o_valid = (r_state == ST_FULL);
  assign o_free  = chan_free(o_valid, i_ready);

`ifdef DEMUX16_COUNT_EN
  logic [COUNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= r_count + COUNT_W'(1);
    end
  end

  assign o_count = r_count;
`endif

endmodule

// File: rtl/demux16_stream.sv
// Registered 1-to-2 stream demux: steers each accepted word to channel A or B.
// Optional per-channel load counters are enabled by defining DEMUX16_COUNT_EN.
module demux16_stream
  import cpu16_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready
`ifdef DEMUX16_COUNT_EN
  ,
  output logic [COUNT_W-1:0] a_count,
  output logic [COUNT_W-1:0] b_count
`endif
);

  logic [N_CH-1:0]  w_ready;
  logic [N_CH-1:0]  w_load;
  logic [N_CH-1:0]  w_valid;
  logic [N_CH-1:0]  w_free;
  logic [WIDTH-1:0] w_data [N_CH];
`ifdef DEMUX16_COUNT_EN
  logic [COUNT_W-1:0] w_count [N_CH];
`endif
  logic             w_accept;

  assign w_ready[CH_A] = a_ready;
  assign w_ready[CH_B] = b_ready;

  // in_ready never looks at in_valid, so no path exists from in_valid to any output.
  assign in_ready = (in_sel == CH_B) ? w_free[CH_B] : w_free[CH_A];
  assign w_accept = in_valid && in_ready;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      assign w_load[gi] = w_accept && (in_sel == gi[0]);

      demux_out_stage #(
        .WIDTH(WIDTH)
      ) u_stage (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load[gi]),
        .i_data  (in_data),
        .i_ready (w_ready[gi]),
        .o_data  (w_data[gi]),
        .o_valid (w_valid[gi]),
        .o_free  (w_free[gi])
`ifdef DEMUX16_COUNT_EN
        ,
        .o_count (w_count[gi])
`endif
      );
    end
  endgenerate

  assign a_data  = w_data[CH_A];
  assign a_valid = w_valid[CH_A];
  assign b_data  = w_data[CH_B];
  assign b_valid = w_valid[CH_B];

`ifdef DEMUX16_COUNT_EN
  assign a_count = w_count[CH_A];
  assign b_count = w_count[CH_B];
`endif

endmodule
